alu_log_reader: RTL and testbench
=================================

ALU_LOG_READER -- requirements
Module: alu_log_reader

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set the log memory address width (16 words).
REQ-002 Parameter ERR_W, default 4, SHALL set the mismatch-counter width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-005 start  input  1  SHALL request a scan; sampled only in IDLE.
REQ-006 base_addr  input  ADDR_W  SHALL give the word address of the first record.
REQ-007 rec_count  input  3  SHALL give the number of records to read; 0 = none.
REQ-008 mem_rd  output  1  SHALL be the log memory read enable.
REQ-009 mem_addr  output  ADDR_W  SHALL be the log memory read address.
REQ-010 mem_rdata  input  16  SHALL be the read data, valid combinationally in the same cycle as mem_rd/mem_addr.
REQ-011 rec_valid / rec_ready  output / input  1 each  SHALL form the record output handshake.
REQ-012 rec_result 16, rec_op1 8, rec_op2 8, rec_opcode 4, rec_mismatch 1 (outputs) SHALL carry the current record.
REQ-013 busy  output  1  SHALL be high in every state except IDLE.
REQ-014 done  output  1  SHALL pulse high for one cycle at scan end.
REQ-015 err_count  output  ERR_W  SHALL count mismatching records since the last accepted start.

Function
REQ-016 Record i SHALL occupy words base_addr+4i+{0,1,2,3} = result, operand1 (bits 7:0), operand2 (bits 7:0), opcode (bits 3:0); address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-017 FSM states SHALL be IDLE, RD_RES, RD_OP1, RD_OP2, RD_OPC, PRESENT, FINISH.
REQ-018 IDLE: start=1 with rec_count!=0 -> RD_RES, capture base/count, clear err_count; start=1 with rec_count=0 -> FINISH; otherwise stay.
REQ-019 Each RD_* state SHALL assert mem_rd for exactly one cycle at the current word address, latch the addressed field, then advance; RD_OPC -> PRESENT.
REQ-020 PRESENT SHALL hold rec_valid=1 and all rec_* stable until rec_ready=1; on handshake: records remaining -> RD_RES at next record address, else -> FINISH.
REQ-021 FINISH SHALL assert done for one cycle, then -> IDLE.
REQ-022 Latency: start sampled at edge 0 -> reads in cycles 1-4 -> rec_valid high from cycle 5; with rec_ready held high, one record per 5 cycles.
REQ-023 rec_mismatch SHALL be 1 when rec_result differs from expected, computed from rec_op1 (a), rec_op2 (b), rec_opcode:
- 0 ADD {0,a+b}; 1 SUB {0,a-b}; 2 AND; 3 OR; 5 NAND; 6 NOR; 7 XOR; 8 XNOR — all {8'h00, 8-bit result}, 8-bit wraparound;
- 4 NOT {~a,~b}; 11 LEFT {a<<1,b<<1}; 12 RIGHT {a>>1,b>>1};
- 9 INC {0,a+1}; 10 DEC {0,a-1}; 13 ARTH {8'h00, a arithmetic-shifted right 1, sign bit kept};
- 14, 15 expected 16'h0000.
REQ-024 err_count SHALL increment at each handshake with rec_mismatch=1 and saturate at all-ones.
REQ-025 start while busy SHALL be ignored; base_addr/rec_count changes after capture SHALL have no effect.
REQ-026 Outside RD_* states mem_rd SHALL be 0 and mem_addr SHALL hold its last value.
REQ-027 rec_valid SHALL be 0 outside PRESENT; rec_* data SHALL hold last record after handshake.

Reset
REQ-028 rst_n=0 SHALL, at any time including mid-scan, force IDLE and all outputs and registers to 0 immediately; no record or done SHALL be emitted for an aborted scan.

Structure
REQ-029 Opcode constants (ADD..ARTH) and FSM state encodings SHALL live in the shared ALU package used by the log writer.
REQ-030 Expected-result computation SHALL be a combinational sub-module alu_ref_model (a, b, opcode -> 16-bit expected).

Verification
REQ-031 Log at base 0: {16'h000C, 5, 7, 0} ready=1 -> reads addrs 0-3 cycles 1-4, rec_valid cycle 5, mismatch=0, done, err_count=0.
REQ-032 Record {16'h0001, 8'h80, 0, 13} -> expected 16'h00C0, mismatch=1, err_count=1.
REQ-033 base=14, count=1 -> mem_addr 14,15,0,1 (wrap).
REQ-034 count=2, rec_ready low 10 cycles in PRESENT -> rec_* stable, no mem_rd, second record read only after handshake.
REQ-035 count=0 -> done one cycle after start, no mem_rd; start during busy -> ignored.
REQ-036 rst_n low during RD_OP2 -> all outputs 0 at once, IDLE, no done.

Source files
------------

// File: rtl/alu_log_reader_pkg.sv
// Shared ALU definitions: opcode constants and the log-reader FSM states.
// Imported by the log reader and by the ALU log writer.
package alu_log_reader_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_NOT  = 4'd4;
   localparam logic [3:0] OP_NAND = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_XNOR = 4'd8;
   localparam logic [3:0] OP_INC  = 4'd9;
   localparam logic [3:0] OP_DEC  = 4'd10;
   localparam logic [3:0] OP_LEFT = 4'd11;
   localparam logic [3:0] OP_RGHT = 4'd12;
   localparam logic [3:0] OP_ARTH = 4'd13;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_RES  = 3'd1,
      ST_RD_OP1  = 3'd2,
      ST_RD_OP2  = 3'd3,
      ST_RD_OPC  = 3'd4,
      ST_PRESENT = 3'd5,
      ST_FINISH  = 3'd6
   } state_t;

endpackage

// File: rtl/alu_log_reader_if.sv
// Control, log-memory read port and record handshake of the log reader.
// master: the reader (drives mem_rd/addr, rec_*); slave: the environment.
interface alu_log_reader_if #(
   parameter int ADDR_W = 4,
   parameter int ERR_W  = 4
);

   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [2:0]        rec_count;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_rdata;
   logic              rec_valid;
   logic              rec_ready;
   logic [15:0]       rec_result;
   logic [7:0]        rec_op1;
   logic [7:0]        rec_op2;
   logic [3:0]        rec_opcode;
   logic              rec_mismatch;
   logic              busy;
   logic              done;
   logic [ERR_W-1:0]  err_count;

   modport master (
      input  start, base_addr, rec_count, mem_rdata, rec_ready,
      output mem_rd, mem_addr, rec_valid, rec_result, rec_op1,
             rec_op2, rec_opcode, rec_mismatch, busy, done, err_count
   );

   modport slave (
      output start, base_addr, rec_count, mem_rdata, rec_ready,
      input  mem_rd, mem_addr, rec_valid, rec_result, rec_op1,
             rec_op2, rec_opcode, rec_mismatch, busy, done, err_count
   );

endinterface

// File: rtl/alu_log_reader_alu_ref_model.sv
// Combinational ALU reference: expected 16-bit result for a, b, opcode.
// Ports: a, b (8b operands), opcode (4b) -> expected (16b).
module alu_ref_model
   import alu_log_reader_pkg::*;
(
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   input  logic [3:0]  opcode,
   output logic [15:0] expected
);

   logic [7:0] sum;
   logic [7:0] dif;
   logic [7:0] inc;
   logic [7:0] dec;

   assign sum = a + b;
   assign dif = a - b;
   assign inc = a + 8'd1;
   assign dec = a - 8'd1;

   always_comb begin
      expected = 16'h0000;
      case (opcode)
         OP_ADD:  expected = {8'h00, sum};
         OP_SUB:  expected = {8'h00, dif};
         OP_AND:  expected = {8'h00, a & b};
         OP_OR:   expected = {8'h00, a | b};
         OP_NOT:  expected = {~a, ~b};
         OP_NAND: expected = {8'h00, ~(a & b)};
         OP_NOR:  expected = {8'h00, ~(a | b)};
         OP_XOR:  expected = {8'h00, a ^ b};
         OP_XNOR: expected = {8'h00, ~(a ^ b)};
         OP_INC:  expected = {8'h00, inc};
         OP_DEC:  expected = {8'h00, dec};
         OP_LEFT: expected = {a[6:0], 1'b0, b[6:0], 1'b0};
         OP_RGHT: expected = {1'b0, a[7:1], 1'b0, b[7:1]};
         OP_ARTH: expected = {8'h00, a[7], a[7:1]};
         default: expected = 16'h0000;
      endcase
   end

endmodule

// File: rtl/alu_log_reader.sv
// Scans ALU log records (result, op1, op2, opcode) from memory, presents
// each over a valid/ready handshake with a mismatch flag, counts errors.
// Ports: clk, rst_n (async, active-low), bus (alu_log_reader_if.master).
module alu_log_reader
   import alu_log_reader_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int ERR_W  = 4
) (
   input logic            clk,
   input logic            rst_n,
   alu_log_reader_if.master bus
);

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        cnt_q;
   logic [15:0]       sh_res_q;
   logic [7:0]        sh_op1_q;
   logic [7:0]        sh_op2_q;
   logic [15:0]       res_q;
   logic [7:0]        op1_q;
   logic [7:0]        op2_q;
   logic [3:0]        opc_q;
   logic [ERR_W-1:0]  err_q;
   logic [15:0]       exp_w;
   logic              mism;
   logic              last;

   alu_ref_model u_ref (
      .a        (op1_q),
      .b        (op2_q),
      .opcode   (opc_q),
      .expected (exp_w)
   );

   assign mism = (exp_w != res_q);
   assign last = (cnt_q == 3'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               if (bus.rec_count != 3'd0) state_d = ST_RD_RES;
               else                       state_d = ST_FINISH;
            end
         end
         ST_RD_RES: state_d = ST_RD_OP1;
         ST_RD_OP1: state_d = ST_RD_OP2;
         ST_RD_OP2: state_d = ST_RD_OPC;
         ST_RD_OPC: state_d = ST_PRESENT;
         ST_PRESENT: begin
            if (bus.rec_ready) begin
               if (last) state_d = ST_FINISH;
               else      state_d = ST_RD_RES;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Fields are staged in shadow registers so the presented record only
   // changes when the next complete record is in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q   <= '0;
         cnt_q    <= '0;
         sh_res_q <= '0;
         sh_op1_q <= '0;
         sh_op2_q <= '0;
         res_q    <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         opc_q    <= '0;
         err_q    <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  err_q <= '0;
                  if (bus.rec_count != 3'd0) begin
                     addr_q <= bus.base_addr;
                     cnt_q  <= bus.rec_count;
                  end
               end
            end
            ST_RD_RES: begin
               sh_res_q <= bus.mem_rdata;
               addr_q   <= addr_q + ADDR_W'(1);
            end
            ST_RD_OP1: begin
               sh_op1_q <= bus.mem_rdata[7:0];
               addr_q   <= addr_q + ADDR_W'(1);
            end
            ST_RD_OP2: begin
               sh_op2_q <= bus.mem_rdata[7:0];
               addr_q   <= addr_q + ADDR_W'(1);
            end
            ST_RD_OPC: begin
               res_q <= sh_res_q;
               op1_q <= sh_op1_q;
               op2_q <= sh_op2_q;
               opc_q <= bus.mem_rdata[3:0];
            end
            ST_PRESENT: begin
               if (bus.rec_ready) begin
                  cnt_q <= cnt_q - 3'd1;
                  // Address stays put after the final record.
                  if (!last) addr_q <= addr_q + ADDR_W'(1);
                  if (mism && (err_q != '1)) err_q <= err_q + ERR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_rd       = (state_q == ST_RD_RES) ||
                             (state_q == ST_RD_OP1) ||
                             (state_q == ST_RD_OP2) ||
                             (state_q == ST_RD_OPC);
   assign bus.mem_addr     = addr_q;
   assign bus.rec_valid    = (state_q == ST_PRESENT);
   assign bus.rec_result   = res_q;
   assign bus.rec_op1      = op1_q;
   assign bus.rec_op2      = op2_q;
   assign bus.rec_opcode   = opc_q;
   assign bus.rec_mismatch = mism;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done         = (state_q == ST_FINISH);
   assign bus.err_count    = err_q;

endmodule

// File: tb/tb_alu_log_reader.sv
// Self-checking bench for alu_log_reader: vector table, corner sequences,
// and randomized multi-record scans against a behavioural model.
module tb_alu_log_reader;

   localparam int AW = 4;
   localparam int EW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   alu_log_reader_if #(.ADDR_W(AW), .ERR_W(EW)) bus ();

   alu_log_reader #(.ADDR_W(AW), .ERR_W(EW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [15:0] mem [16];
   assign bus.mem_rdata = mem[bus.mem_addr];

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  base;
      logic [15:0] res;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [3:0]  opc;
      logic        mism;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_exp(input int a, input int b,
                                           input int op);
      int hi;
      int lo;
      hi = 0;
      lo = 0;
      case (op)
         0:  lo = (a + b) % 256;
         1:  lo = (a - b + 256) % 256;
         2:  lo = a & b;
         3:  lo = a | b;
         4:  begin hi = 255 - a; lo = 255 - b; end
         5:  lo = 255 - (a & b);
         6:  lo = 255 - (a | b);
         7:  lo = a ^ b;
         8:  lo = 255 - (a ^ b);
         9:  lo = (a + 1) % 256;
         10: lo = (a + 255) % 256;
         11: begin hi = (a * 2) % 256; lo = (b * 2) % 256; end
         12: begin hi = a / 2; lo = b / 2; end
         13: lo = a / 2 + ((a >= 128) ? 128 : 0);
         default: ;
      endcase
      return 16'(hi * 256 + lo);
   endfunction

   task automatic put_rec(input logic [3:0] base, input logic [15:0] res,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] opc);
      mem[4'(base + 4'd0)] = res;
      mem[4'(base + 4'd1)] = {8'hA5, a};
      mem[4'(base + 4'd2)] = {8'h5A, b};
      mem[4'(base + 4'd3)] = {12'hBCD, opc};
   endtask

   // Call just after a rising edge with the DUT idle; returns just after
   // the edge that samples start.
   task automatic start_scan(input logic [3:0] base, input logic [2:0] cnt);
      bus.start     = 1'b1;
      bus.base_addr = base;
      bus.rec_count = cnt;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.base_addr = 4'($urandom);
      bus.rec_count = 3'($urandom);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  bus.busy, 0);
      chk({tag, "_done"},  bus.done, 0);
      chk({tag, "_rd"},    bus.mem_rd, 0);
      chk({tag, "_addr"},  bus.mem_addr, 0);
      chk({tag, "_valid"}, bus.rec_valid, 0);
      chk({tag, "_res"},   bus.rec_result, 0);
      chk({tag, "_ops"},   {bus.rec_op1, bus.rec_op2, bus.rec_opcode}, 0);
      chk({tag, "_mism"},  bus.rec_mismatch, 0);
      chk({tag, "_err"},   bus.err_count, 0);
   endtask

   initial begin
      logic [15:0] e_res [8];
      logic [7:0]  e_a [8];
      logic [7:0]  e_b [8];
      logic [3:0]  e_opc [8];
      logic        e_mism [8];
      int          errs;
      int          idx;
      logic        got_done;
      logic [3:0]  rb;
      logic [2:0]  rc;

      vt[0]  = '{4'd0,  16'h000C, 8'h05, 8'h07, 4'd0,  1'b0};
      vt[1]  = '{4'd4,  16'h0001, 8'h80, 8'h00, 4'd13, 1'b1};
      vt[2]  = '{4'd14, 16'hFAF5, 8'h05, 8'h0A, 4'd4,  1'b0};
      vt[3]  = '{4'd8,  16'h00FE, 8'h7F, 8'h7F, 4'd0,  1'b0};
      vt[4]  = '{4'd2,  16'h00FE, 8'h03, 8'h05, 4'd1,  1'b0};
      vt[5]  = '{4'd9,  16'h0204, 8'h81, 8'h82, 4'd11, 1'b0};
      vt[6]  = '{4'd5,  16'h4041, 8'h81, 8'h83, 4'd12, 1'b0};
      vt[7]  = '{4'd11, 16'h0000, 8'h12, 8'h34, 4'd15, 1'b0};
      vt[8]  = '{4'd7,  16'h0001, 8'h12, 8'h34, 4'd14, 1'b1};
      vt[9]  = '{4'd13, 16'h00FF, 8'h00, 8'h33, 4'd10, 1'b0};
      vt[10] = '{4'd1,  16'h0000, 8'hF0, 8'h0F, 4'd8,  1'b0};
      vt[11] = '{4'd12, 16'h0100, 8'hFF, 8'hFF, 4'd5,  1'b1};
      vt[12] = '{4'd3,  16'h0030, 8'h3C, 8'hF0, 4'd2,  1'b0};
      vt[13] = '{4'd6,  16'h00FC, 8'h3C, 8'hF0, 4'd3,  1'b0};
      vt[14] = '{4'd10, 16'h00CD, 8'h3C, 8'hF0, 4'd7,  1'b1};
      vt[15] = '{4'd15, 16'h0000, 8'hFF, 8'h11, 4'd9,  1'b0};
      vt[16] = '{4'd0,  16'h003F, 8'h7E, 8'h01, 4'd13, 1'b0};

      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.rec_count = '0;
      bus.rec_ready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single-record vectors with exact cycle-by-cycle latency.
      for (int v = 0; v < 17; v++) begin
         put_rec(vt[v].base, vt[v].res, vt[v].a, vt[v].b, vt[v].opc);
         bus.rec_ready = 1'b1;
         start_scan(vt[v].base, 3'd1);
         for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_rd%0d", v, k), bus.mem_rd, 1);
            chk($sformatf("v%0d_addr%0d", v, k), bus.mem_addr,
                4'(vt[v].base + 4'(k)));
         end
         @(negedge clk);
         chk($sformatf("v%0d_valid", v), bus.rec_valid, 1);
         chk($sformatf("v%0d_res", v), bus.rec_result, vt[v].res);
         chk($sformatf("v%0d_op1", v), bus.rec_op1, vt[v].a);
         chk($sformatf("v%0d_op2", v), bus.rec_op2, vt[v].b);
         chk($sformatf("v%0d_opc", v), bus.rec_opcode, vt[v].opc);
         chk($sformatf("v%0d_mism", v), bus.rec_mismatch, vt[v].mism);
         @(negedge clk);
         chk($sformatf("v%0d_done", v), bus.done, 1);
         chk($sformatf("v%0d_vlow", v), bus.rec_valid, 0);
         chk($sformatf("v%0d_rdlow", v), bus.mem_rd, 0);
         chk($sformatf("v%0d_hold", v), bus.mem_addr,
             4'(vt[v].base + 4'd3));
         @(negedge clk);
         chk($sformatf("v%0d_donelow", v), bus.done, 0);
         chk($sformatf("v%0d_idle", v), bus.busy, 0);
         chk($sformatf("v%0d_err", v), bus.err_count, vt[v].mism);
         @(posedge clk);
         #1;
      end

      // Back-pressure: two records, ready held low for 10 cycles.
      put_rec(4'd3, 16'h0011, 8'h08, 8'h09, 4'd0);
      put_rec(4'd7, 16'h0005, 8'h06, 8'h03, 4'd1);
      bus.rec_ready = 1'b0;
      start_scan(4'd3, 3'd2);
      repeat (4) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("stall_valid", bus.rec_valid, 1);
         chk("stall_rd", bus.mem_rd, 0);
         chk("stall_res", bus.rec_result, 16'h0011);
         chk("stall_ops", {bus.rec_op1, bus.rec_op2, bus.rec_opcode},
             {8'h08, 8'h09, 4'd0});
      end
      bus.rec_ready = 1'b1;
      @(negedge clk);
      chk("stall_next_rd", bus.mem_rd, 1);
      chk("stall_next_addr", bus.mem_addr, 7);
      chk("stall_next_vlow", bus.rec_valid, 0);
      chk("stall_keep_res", bus.rec_result, 16'h0011);
      repeat (3) @(negedge clk);
      @(negedge clk);
      chk("stall_rec2_valid", bus.rec_valid, 1);
      chk("stall_rec2_res", bus.rec_result, 16'h0005);
      chk("stall_rec2_mism", bus.rec_mismatch, 1);
      @(negedge clk);
      chk("stall_done", bus.done, 1);
      chk("stall_err", bus.err_count, 1);
      @(posedge clk);
      #1;

      // Zero-record scan.
      start_scan(4'd5, 3'd0);
      @(negedge clk);
      chk("zero_done", bus.done, 1);
      chk("zero_rd", bus.mem_rd, 0);
      chk("zero_err_clr", bus.err_count, 0);
      @(negedge clk);
      chk("zero_donelow", bus.done, 0);
      chk("zero_idle", bus.busy, 0);
      @(posedge clk);
      #1;

      // Start while busy is ignored.
      put_rec(4'd0, 16'h000C, 8'h05, 8'h07, 4'd0);
      bus.rec_ready = 1'b1;
      start_scan(4'd0, 3'd1);
      bus.start     = 1'b1;
      bus.base_addr = 4'd8;
      bus.rec_count = 3'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("busy_start_addr", bus.mem_addr, 4'(k));
      end
      bus.start = 1'b0;
      @(negedge clk);
      chk("busy_start_valid", bus.rec_valid, 1);
      chk("busy_start_res", bus.rec_result, 16'h000C);
      @(negedge clk);
      chk("busy_start_done", bus.done, 1);
      @(negedge clk);
      chk("busy_start_idle", bus.busy, 0);
      @(posedge clk);
      #1;

      // Reset during RD_OP2 aborts without a record or done.
      put_rec(4'd6, 16'h1234, 8'h11, 8'h22, 4'd3);
      start_scan(4'd6, 3'd2);
      repeat (3) @(negedge clk);
      chk("abort_in_op2", bus.mem_addr, 8);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort");
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_hold_done", bus.done, 0);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("abort_quiet", {bus.done, bus.rec_valid, bus.busy}, 0);
      end
      @(posedge clk);
      #1;

      // Randomized multi-record scans with random back-pressure.
      for (int s = 0; s < 30; s++) begin
         rb = 4'($urandom);
         rc = 3'($urandom_range(1, 7));
         for (int w = 0; w < 16; w++) mem[w] = 16'($urandom);
         for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1)
               mem[4'(rb + 4'(4 * r))] = ref_exp(
                  int'(mem[4'(rb + 4'(4 * r + 1))][7:0]),
                  int'(mem[4'(rb + 4'(4 * r + 2))][7:0]),
                  int'(mem[4'(rb + 4'(4 * r + 3))][3:0]));
         end
         errs = 0;
         for (int i = 0; i < int'(rc); i++) begin
            e_res[i]  = mem[4'(rb + 4'(4 * i))];
            e_a[i]    = mem[4'(rb + 4'(4 * i + 1))][7:0];
            e_b[i]    = mem[4'(rb + 4'(4 * i + 2))][7:0];
            e_opc[i]  = mem[4'(rb + 4'(4 * i + 3))][3:0];
            e_mism[i] = (e_res[i] != ref_exp(int'(e_a[i]), int'(e_b[i]),
                                              int'(e_opc[i])));
            if (e_mism[i]) errs++;
         end
         bus.rec_ready = 1'b0;
         start_scan(rb, rc);
         idx = 0;
         got_done = 1'b0;
         for (int c = 0; c < 300 && !got_done; c++) begin
            bus.rec_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.rec_valid && bus.rec_ready) begin
               if (idx < int'(rc)) begin
                  chk("rnd_res", bus.rec_result, e_res[idx]);
                  chk("rnd_ops", {bus.rec_op1, bus.rec_op2, bus.rec_opcode},
                      {e_a[idx], e_b[idx], e_opc[idx]});
                  chk("rnd_mism", bus.rec_mismatch, e_mism[idx]);
               end
               idx++;
            end
            if (bus.done) got_done = 1'b1;
            @(posedge clk);
            #1;
         end
         chk("rnd_done", got_done, 1);
         chk("rnd_nrec", idx, rc);
         chk("rnd_err", bus.err_count, (errs > 3) ? 3 : errs);
         chk("rnd_idle", bus.busy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
